// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bundle: decoded ID-stage inputs, registered EX-stage outputs and hazard status.
// The stage module takes the slave modport; the upstream driver (or bench) takes master.
interface id_ex_stage_if;
  logic [1:0]  id_wb;
  logic [1:0]  id_mem;
  logic [3:0]  id_ex;
  logic [31:0] id_pc4;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        flush;

  logic [1:0]  ex_wb;
  logic [1:0]  ex_mem;
  logic [3:0]  ex_ex;
  logic [31:0] ex_pc4;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        stall;
  logic [15:0] bubble_cnt;

  modport master (
    output id_wb, id_mem, id_ex, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    input  ex_wb, ex_mem, ex_ex, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
    input  ex_valid, stall, bubble_cnt
  );

  modport slave (
    input  id_wb, id_mem, id_ex, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, flush,
    output ex_wb, ex_mem, ex_ex, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
    output ex_valid, stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Define ID_EX_PERF_CNT_EN to build the saturating bubble counter; otherwise bubble_cnt is 0.
module id_ex_stage (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic [1:0]  wb_q, mem_q;
  logic [3:0]  ex_q;
  logic [31:0] pc4_q, rd1_q, rd2_q, imm_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic        valid_q;

  logic hazard;
  logic bubble;

  // Load in EX whose destination is a source of the ID instruction; $zero never hazards.
  always_comb begin
    hazard = mem_q[1] & valid_q & (rt_q != 5'd0) &
             ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
    bubble = hazard | bus.flush;
  end

  assign bus.stall = hazard & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q    <= '0;
      mem_q   <= '0;
      ex_q    <= '0;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // A bubble zeroes only control; datapath still follows ID.
      wb_q    <= bubble ? 2'b00 : bus.id_wb;
      mem_q   <= bubble ? 2'b00 : bus.id_mem;
      ex_q    <= bubble ? 4'b0000 : bus.id_ex;
      valid_q <= ~bubble;
      pc4_q   <= bus.id_pc4;
      rd1_q   <= bus.id_rd1;
      rd2_q   <= bus.id_rd2;
      imm_q   <= bus.id_imm;
      rs_q    <= bus.id_rs;
      rt_q    <= bus.id_rt;
      rd_q    <= bus.id_rd;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.bubble_cnt = cnt_q;
`else
  assign bus.bubble_cnt = 16'h0000;
`endif

  assign bus.ex_wb    = wb_q;
  assign bus.ex_mem   = mem_q;
  assign bus.ex_ex    = ex_q;
  assign bus.ex_pc4   = pc4_q;
  assign bus.ex_rd1   = rd1_q;
  assign bus.ex_rd2   = rd2_q;
  assign bus.ex_imm   = imm_q;
  assign bus.ex_rs    = rs_q;
  assign bus.ex_rt    = rt_q;
  assign bus.ex_rd    = rd_q;
  assign bus.ex_valid = valid_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- id_wb  in  2  {RegWrite, MemToReg} from control decode
- id_mem  in  2  {MemRead, MemWrite} from control decode
- id_ex  in  4  {RegDest, ALUOp[1:0], ALUSrc} from control decode
- id_pc4  in  32  PC+4 of ID instruction
- id_rd1, id_rd2  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers of ID instruction
- flush  in  1  taken branch/jump; squash ID instruction
- ex_wb, ex_mem, ex_ex  out  2/2/4  registered control bundles
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  32 each  registered datapath
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- ex_valid  out  1  EX holds a real (non-bubble) instruction
- stall  out  1  load-use hazard; upstream holds PC and IF/ID
- bubble_cnt  out  16  bubbles inserted (see Configuration)

Function
REQ-002 SHALL capture all id_* inputs into ex_* registers every clk rising edge; latency 1 cycle, no enable.
REQ-003 SHALL compute hazard = ex_mem[1] & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)), combinationally from registered state and ID inputs.
REQ-004 SHALL drive stall = hazard & ~flush.
REQ-005 SHALL insert a bubble when hazard or flush is 1: ex_wb, ex_mem, ex_ex load 0, ex_valid loads 0; datapath and specifier fields load id_* values normally.
REQ-006 SHALL load ex_valid = 1 when no bubble is inserted.
REQ-007 SHALL give flush priority over hazard: flush and hazard both 1 -> one bubble, stall = 0.
REQ-008 Stall SHALL last exactly one cycle per load-use pair: the bubble clears ex_mem[1], so hazard drops next cycle and the held instruction enters EX.
REQ-009 SHALL treat ex_rt == 0 as no hazard (register $zero).
REQ-010 Bubble SHALL be all-zero control, so no register or memory write occurs downstream.

Reset
REQ-011 rst_n low SHALL asynchronously clear every ex_* output, ex_valid and bubble_cnt to 0; stall then evaluates to 0.
REQ-012 Deassertion of rst_n SHALL be sampled at the next clk edge; the first edge with rst_n high captures ID normally.
REQ-013 Reset during a stall SHALL abort it: state cleared, no pending bubble retained.

Configuration
REQ-014 Macro ID_EX_PERF_CNT_EN defined: bubble_cnt SHALL increment by 1 on each clk edge where a bubble is inserted (hazard or flush), saturating at 16'hFFFF.
REQ-015 Macro ID_EX_PERF_CNT_EN undefined: bubble_cnt SHALL be tied to 0 with no counter register; all other behaviour unchanged.

Verification
REQ-016 Bench SHALL cover:
- Reset: rst_n=0 mid-cycle with nonzero ex_* -> all outputs 0 immediately, before the next edge.
- Pass-through: id_ex=4'b1101, id_wb=2'b10, id_rd1=32'h1234_5678, no hazard -> next edge ex_ex=4'b1101, ex_wb=2'b10, ex_rd1=32'h1234_5678, ex_valid=1.
- Load-use: lw with rt=5 in EX (ex_mem=2'b10), ID id_rs=5 -> stall=1, next edge ex_wb/ex_mem/ex_ex=0, ex_valid=0; following cycle stall=0.
- $zero: lw rt=0 in EX, id_rs=0 -> stall=0, no bubble.
- Flush+hazard: conditions of the load-use case plus flush=1 -> stall=0, one bubble, bubble_cnt +1 (with ID_EX_PERF_CNT_EN).
- Saturation: with ID_EX_PERF_CNT_EN, preload 16'hFFFE, insert 3 bubbles -> bubble_cnt=16'hFFFF; macro undefined -> bubble_cnt stays 0.
